// File: rtl/axi_aib_tx_chan_arb.sv
`default_nettype none
// ============================================================================
// Module  : axi_aib_tx_chan_arb
// Brief   : Credit-based round-robin scheduler for AR/AW/W onto one AIB TX link,
//           keeping W bursts atomic. Optional macro: AXI_AIB_ARB_DEBUG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module axi_aib_tx_chan_arb #(
  parameter int DWIDTH = 40,
  parameter int CRW    = 8
) (
  input  logic              clk_wr,
  input  logic              rst_wr_n,
  input  logic              i_link_en,
  input  logic [CRW-1:0]    i_init_ar_credit,
  input  logic [CRW-1:0]    i_init_aw_credit,
  input  logic [CRW-1:0]    i_init_w_credit,
  input  logic              i_ar_valid,
  output logic              o_ar_ready,
  input  logic [DWIDTH-1:0] i_ar_data,
  input  logic              i_aw_valid,
  output logic              o_aw_ready,
  input  logic [DWIDTH-1:0] i_aw_data,
  input  logic              i_w_valid,
  output logic              o_w_ready,
  input  logic [DWIDTH-1:0] i_w_data,
  input  logic              i_w_last,
  input  logic              i_ar_credit_ret,
  input  logic              i_aw_credit_ret,
  input  logic              i_w_credit_ret,
  output logic              o_link_valid,
  input  logic              i_link_ready,
  output logic [DWIDTH-1:0] o_link_data,
  output logic [1:0]        o_link_chan,
  output logic [CRW-1:0]    o_ar_credit,
  output logic [CRW-1:0]    o_aw_credit,
  output logic [CRW-1:0]    o_w_credit,
  output logic              o_err_credit_ovf
`ifdef AXI_AIB_ARB_DEBUG_EN
  ,
  output logic [31:0]       o_debug_status
`endif
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCK_W = 1'b1} state_t;

  localparam logic [1:0]     C_CH_W    = 2'd2;
  localparam logic [CRW-1:0] C_CR_MAX  = '1;
  localparam logic [CRW-1:0] C_CR_ONE  = CRW'(1);

  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

  state_t                  state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic                    link_valid_q, link_valid_d;
  logic [DWIDTH-1:0]       link_data_q, link_data_d;
  logic [1:0]              link_chan_q, link_chan_d;
  logic [2:0][CRW-1:0]     cr_q, cr_d;
  logic                    err_ovf_q, err_ovf_d;

  logic [2:0]              req, ret, elig, gnt;
  logic [2:0][DWIDTH-1:0]  data_in;
  logic [2:0][CRW-1:0]     cr_init;
  logic                    slot_free, gnt_any;
  logic [1:0]              gnt_idx, cand;

  assign req     = {i_w_valid, i_aw_valid, i_ar_valid};
  assign ret     = {i_w_credit_ret, i_aw_credit_ret, i_ar_credit_ret};
  assign data_in = {i_w_data, i_aw_data, i_ar_data};
  assign cr_init = {i_init_w_credit, i_init_aw_credit, i_init_ar_credit};

  always_comb begin
    slot_free = !link_valid_q || i_link_ready;
    // Only W may win while a W burst holds the link.
    for (int c = 0; c < 3; c++) begin
      elig[c] = rst_wr_n && req[c] && (cr_q[c] != '0) && i_link_en && slot_free &&
                ((state_q == ST_IDLE) || (c == 2));
    end

    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
      cand = next_ch(cand);
    end
    gnt = gnt_any ? (3'b001 << gnt_idx) : 3'b000;

    state_d      = state_q;
    ptr_d        = ptr_q;
    link_valid_d = link_valid_q;
    link_data_d  = link_data_q;
    link_chan_d  = link_chan_q;
    if (gnt_any) begin
      link_valid_d = 1'b1;
      link_data_d  = data_in[gnt_idx];
      link_chan_d  = gnt_idx;
      if (state_q == ST_IDLE) ptr_d = next_ch(gnt_idx);
      if (gnt_idx == C_CH_W) state_d = i_w_last ? ST_IDLE : ST_LOCK_W;
    end else if (slot_free) begin
      link_valid_d = 1'b0;
    end

    err_ovf_d = err_ovf_q;
    cr_d      = cr_q;
    for (int c = 0; c < 3; c++) begin
      if (gnt[c] && !ret[c]) begin
        cr_d[c] = cr_q[c] - C_CR_ONE;
      end else if (!gnt[c] && ret[c]) begin
        if (cr_q[c] == C_CR_MAX) err_ovf_d = 1'b1;
        else                     cr_d[c]   = cr_q[c] + C_CR_ONE;
      end
    end
  end

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 2'd0;
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      link_chan_q  <= 2'd0;
      cr_q         <= cr_init;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      link_valid_q <= link_valid_d;
      link_data_q  <= link_data_d;
      link_chan_q  <= link_chan_d;
      cr_q         <= cr_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign o_ar_ready       = gnt[0];
  assign o_aw_ready       = gnt[1];
  assign o_w_ready        = gnt[2];
  assign o_link_valid     = link_valid_q;
  assign o_link_data      = link_data_q;
  assign o_link_chan      = link_chan_q;
  assign o_ar_credit      = cr_q[0];
  assign o_aw_credit      = cr_q[1];
  assign o_w_credit       = cr_q[2];
  assign o_err_credit_ovf = err_ovf_q;

`ifdef AXI_AIB_ARB_DEBUG_EN
  logic [2:0][9:0] gcnt_q, gcnt_d;

  always_comb begin
    for (int c = 0; c < 3; c++) gcnt_d[c] = gcnt_q[c] + {9'd0, gnt[c]};
  end

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) gcnt_q <= '0;
    else           gcnt_q <= gcnt_d;
  end

  assign o_debug_status = {gcnt_q[2], gcnt_q[1], gcnt_q[0], state_q, err_ovf_q};
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_aib_tx_chan_arb.sv
`default_nettype none
// Randomized and directed bench for axi_aib_tx_chan_arb with a queue-based
// scoreboard fed by a channel-level reference model.
module tb_axi_aib_tx_chan_arb;
  localparam int DW  = 40;
  localparam int CRW = 8;

  logic          clk_wr = 1'b0;
  logic          rst_wr_n = 1'b0;
  logic          i_link_en = 1'b0;
  logic [CRW-1:0] i_init_ar_credit = 8'd2, i_init_aw_credit = 8'd2, i_init_w_credit = 8'd2;
  logic          i_ar_valid = 1'b0, i_aw_valid = 1'b0, i_w_valid = 1'b0, i_w_last = 1'b0;
  logic [DW-1:0] i_ar_data = '0, i_aw_data = '0, i_w_data = '0;
  logic          i_ar_credit_ret = 1'b0, i_aw_credit_ret = 1'b0, i_w_credit_ret = 1'b0;
  logic          i_link_ready = 1'b0;
  logic          o_ar_ready, o_aw_ready, o_w_ready, o_link_valid, o_err_credit_ovf;
  logic [DW-1:0] o_link_data;
  logic [1:0]    o_link_chan;
  logic [CRW-1:0] o_ar_credit, o_aw_credit, o_w_credit;
`ifdef AXI_AIB_ARB_DEBUG_EN
  logic [31:0]   o_debug_status;
`endif

  always #5 clk_wr = ~clk_wr;

  axi_aib_tx_chan_arb #(.DWIDTH(DW), .CRW(CRW)) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .i_link_en(i_link_en),
    .i_init_ar_credit(i_init_ar_credit), .i_init_aw_credit(i_init_aw_credit),
    .i_init_w_credit(i_init_w_credit),
    .i_ar_valid(i_ar_valid), .o_ar_ready(o_ar_ready), .i_ar_data(i_ar_data),
    .i_aw_valid(i_aw_valid), .o_aw_ready(o_aw_ready), .i_aw_data(i_aw_data),
    .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w_data(i_w_data), .i_w_last(i_w_last),
    .i_ar_credit_ret(i_ar_credit_ret), .i_aw_credit_ret(i_aw_credit_ret),
    .i_w_credit_ret(i_w_credit_ret),
    .o_link_valid(o_link_valid), .i_link_ready(i_link_ready),
    .o_link_data(o_link_data), .o_link_chan(o_link_chan),
    .o_ar_credit(o_ar_credit), .o_aw_credit(o_aw_credit), .o_w_credit(o_w_credit),
    .o_err_credit_ovf(o_err_credit_ovf)
`ifdef AXI_AIB_ARB_DEBUG_EN
    , .o_debug_status(o_debug_status)
`endif
  );

  int  n_vec = 0;
  int  n_err = 0;
  int  m_cr[3];
  int  m_ptr = 0;
  bit  m_lock = 0, m_valid = 0, m_ovf = 0, m_after_rst = 0;
  logic [DW+1:0] sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: channel-level credit/arbitration rules applied once per cycle.
  task automatic model_eval();
    logic [2:0]    v, r, rdy;
    logic [DW-1:0] d[3];
    bit            free;
    int            g, c;
    v = {i_w_valid, i_aw_valid, i_ar_valid};
    r = {i_w_credit_ret, i_aw_credit_ret, i_ar_credit_ret};
    rdy = {o_w_ready, o_aw_ready, o_ar_ready};
    d[0] = i_ar_data; d[1] = i_aw_data; d[2] = i_w_data;
    chk("link_valid", 64'(o_link_valid), 64'(m_valid));
    chk("ar_credit", 64'(o_ar_credit), 64'(m_cr[0]));
    chk("aw_credit", 64'(o_aw_credit), 64'(m_cr[1]));
    chk("w_credit", 64'(o_w_credit), 64'(m_cr[2]));
    chk("credit_ovf", 64'(o_err_credit_ovf), 64'(m_ovf));
    if (m_after_rst) begin
      chk("rst_data", 64'(o_link_data), 64'd0);
      chk("rst_chan", 64'(o_link_chan), 64'd0);
    end
    if (!rst_wr_n) begin
      chk("ready_in_rst", 64'(rdy), 64'd0);
      m_cr[0] = int'(i_init_ar_credit); m_cr[1] = int'(i_init_aw_credit);
      m_cr[2] = int'(i_init_w_credit);
      m_ptr = 0; m_lock = 0; m_valid = 0; m_ovf = 0; m_after_rst = 1;
      sb.delete();
      return;
    end
    m_after_rst = 0;
    free = !m_valid || i_link_ready;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      c = (m_ptr + k) % 3;
      if (g < 0 && v[c] && m_cr[c] > 0 && i_link_en && free && (!m_lock || c == 2)) g = c;
    end
    chk("ready", 64'(rdy), (g < 0) ? 64'd0 : (64'd1 << g));
    if (g >= 0) begin
      sb.push_back({2'(g), d[g]});
      m_valid = 1;
      if (!m_lock) m_ptr = (g + 1) % 3;
      if (g == 2) m_lock = !i_w_last;
    end else if (free) begin
      m_valid = 0;
    end
    for (int k = 0; k < 3; k++) begin
      m_cr[k] = m_cr[k] - ((g == k) ? 1 : 0) + (r[k] ? 1 : 0);
      if (m_cr[k] > 255) begin
        m_cr[k] = 255;
        m_ovf = 1;
      end
    end
  endtask

  always @(negedge clk_wr) begin
    if (rst_wr_n && o_link_valid && i_link_ready) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL flit_unexpected: got chan %0d data %0h expected none", o_link_chan, o_link_data);
      end else begin
        chk("flit", 64'({o_link_chan, o_link_data}), 64'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(negedge clk_wr);
    model_eval();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic do_reset(input int ar, input int aw, input int w);
    i_init_ar_credit = CRW'(ar); i_init_aw_credit = CRW'(aw); i_init_w_credit = CRW'(w);
    rst_wr_n = 1'b0;
    tick(); tick();
    rst_wr_n = 1'b1;
  endtask

  task automatic idle_inputs();
    i_ar_valid = 0; i_aw_valid = 0; i_w_valid = 0; i_w_last = 0;
    i_ar_credit_ret = 0; i_aw_credit_ret = 0; i_w_credit_ret = 0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  initial begin
    m_cr[0] = 2; m_cr[1] = 2; m_cr[2] = 2;
    // Round robin with 2 credits each
    do_reset(2, 2, 2);
    i_link_en = 1; i_link_ready = 1;
    i_ar_valid = 1; i_aw_valid = 1; i_w_valid = 1; i_w_last = 1;
    repeat (8) begin
      i_ar_data = rnd_data(); i_aw_data = rnd_data(); i_w_data = rnd_data();
      tick();
    end
    idle_inputs();

    // Atomic W burst of 4 with AR/AW arriving behind it
    do_reset(4, 4, 8);
    for (int cyc = 0; cyc < 8; cyc++) begin
      i_w_valid = (cyc < 4); i_w_last = (cyc == 3);
      i_ar_valid = (cyc >= 1); i_aw_valid = (cyc >= 1);
      i_ar_data = rnd_data(); i_aw_data = rnd_data(); i_w_data = rnd_data();
      tick();
    end
    idle_inputs();

    // Back-pressure on an AW flit
    do_reset(4, 4, 4);
    i_link_ready = 0; i_aw_valid = 1; i_aw_data = 40'h12_3456_789A;
    tick();
    i_aw_data = rnd_data();
    repeat (3) begin
      tick();
      chk("stall_data", 64'(o_link_data), 64'h12_3456_789A);
      chk("stall_chan", 64'(o_link_chan), 64'd1);
    end
    i_link_ready = 1; i_aw_valid = 0;
    tick(); tick();

    // Zero AR credit replenished by a return pulse
    do_reset(0, 4, 4);
    i_ar_valid = 1; i_ar_data = rnd_data();
    tick();
    i_ar_credit_ret = 1;
    tick();
    i_ar_credit_ret = 0;
    tick();
    i_ar_valid = 0;
    tick(); tick();

    // Credit overflow is saturating and sticky
    do_reset(4, 255, 4);
    i_aw_credit_ret = 1;
    tick();
    i_aw_credit_ret = 0;
    repeat (3) tick();
    chk("ovf_sticky", 64'(o_err_credit_ovf), 64'd1);

    // Reset in the middle of a locked W burst
    do_reset(4, 4, 8);
    i_w_valid = 1; i_w_last = 0; i_w_data = rnd_data();
    tick();
    i_ar_valid = 1; i_ar_data = rnd_data();
    tick(); tick();
    do_reset(4, 4, 8);
    tick();
    chk("ar_first_after_rst", 64'({o_link_valid, o_link_chan}), 64'({1'b1, 2'd0}));
    idle_inputs();
    tick();

    // Randomized traffic
    repeat (6) begin
      do_reset($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      repeat (300) begin
        i_ar_valid = ($urandom % 4) != 0; i_aw_valid = ($urandom % 4) != 0;
        i_w_valid  = ($urandom % 4) != 0; i_w_last = ($urandom % 3) == 0;
        i_ar_data = rnd_data(); i_aw_data = rnd_data(); i_w_data = rnd_data();
        i_link_ready = ($urandom % 4) != 0; i_link_en = ($urandom % 8) != 0;
        i_ar_credit_ret = ($urandom % 6) == 0; i_aw_credit_ret = ($urandom % 6) == 0;
        i_w_credit_ret = ($urandom % 6) == 0;
        tick();
      end
    end

    idle_inputs();
    i_link_ready = 1;
    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
